// File: rtl/mul_booth64.sv
// Iterative radix-4 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH product, one operation in flight.
// Optional: define MUL_EARLY_EXIT_EN to send zero operands straight from INIT to DONE.
module mul_booth64 #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [1:0]       sign,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             busy,
   output logic             finish
);

   localparam int ITER = WIDTH / 2 + 1;
   localparam int EW   = WIDTH + 2;      // extended operand width
   localparam int AW   = EW + 1;         // accumulator keeps a carry guard bit so +/-2M never overflows
   localparam int PW   = AW + EW + 1;    // {accumulator, multiplier, booth guard}
   localparam int CW   = $clog2(ITER);

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      INIT = 4'b0010,
      CALC = 4'b0100,
      DONE = 4'b1000
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] x_q, y_q;
   logic             xs_q, ys_q;
   logic [EW-1:0]    m_q;
   logic [PW-1:0]    p_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             busy_q, finish_q;

   logic [AW-1:0]    acc, m1, m2, sum_d;
   logic [PW-1:0]    p_d;

   always_comb begin
      acc = p_q[PW-1 -: AW];
      m1  = {m_q[EW-1], m_q};
      m2  = {m_q, 1'b0};
      case (p_q[2:0])
         3'b001, 3'b010: sum_d = acc + m1;
         3'b011:         sum_d = acc + m2;
         3'b100:         sum_d = acc - m2;
         3'b101, 3'b110: sum_d = acc - m1;
         default:        sum_d = acc;
      endcase
      p_d = $signed({sum_d, p_q[EW:0]}) >>> 2;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         xs_q     <= 1'b0;
         ys_q     <= 1'b0;
         m_q      <= '0;
         p_q      <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid) begin
                  x_q     <= x;
                  y_q     <= y;
                  xs_q    <= sign[1];
                  ys_q    <= sign[1] & sign[0];   // 2'b01 behaves as unsigned x unsigned
                  busy_q  <= 1'b1;
                  state_q <= INIT;
               end
            end
            INIT: begin
               m_q     <= {{2{xs_q & x_q[WIDTH-1]}}, x_q};
               p_q     <= {{AW{1'b0}}, {2{ys_q & y_q[WIDTH-1]}}, y_q, 1'b0};
               cnt_q   <= '0;
               state_q <= CALC;
`ifdef MUL_EARLY_EXIT_EN
               if (x_q == '0 || y_q == '0) begin
                  hi_q     <= '0;
                  lo_q     <= '0;
                  finish_q <= 1'b1;
                  state_q  <= DONE;
               end
`endif
            end
            CALC: begin
               p_q   <= p_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(ITER - 1)) begin
                  // product starts just above the booth guard bit
                  hi_q     <= p_d[2*WIDTH:WIDTH+1];
                  lo_q     <= p_d[WIDTH:1];
                  finish_q <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               finish_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               finish_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign result_hi = hi_q;
   assign result_lo = lo_q;
   assign busy      = busy_q;
   assign finish    = finish_q;

endmodule

// File: tb/tb_mul_booth64.sv
// Self-checking bench for mul_booth64: scoreboard queue of expected products, latency and handshake checks.
// Honours MUL_EARLY_EXIT_EN for the expected latency of zero operands.
module tb_mul_booth64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [1:0]  sign = 2'b00;
   logic [63:0] x = '0;
   logic [63:0] y = '0;
   logic [63:0] result_hi, result_lo;
   logic        busy, finish;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int t_acc = 0;
   logic [127:0] sb[$];
   logic [63:0]  got_hi, got_lo;

`ifdef MUL_EARLY_EXIT_EN
   localparam int ZERO_LAT = 2;
`else
   localparam int ZERO_LAT = 35;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_booth64 dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .sign(sign), .x(x), .y(y),
      .result_hi(result_hi), .result_lo(result_lo), .busy(busy), .finish(finish)
   );

   function automatic logic [127:0] model(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] ea, eb;
      ea = s[1] ? {{64{a[63]}}, a} : {64'd0, a};
      eb = (s == 2'b11) ? {{64{b[63]}}, b} : {64'd0, b};
      return ea * eb;
   endfunction

   // Called at a negedge; the following posedge is the acceptance edge T.
   task automatic issue(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
      sign = s; x = a; y = b; valid = 1'b1;
      @(posedge clk); #1;
      t_acc = cyc;
      valid = 1'b0;
      sign = ~s; x = {$urandom, $urandom}; y = {$urandom, $urandom};
   endtask

   // lat is the cycle index (relative to T) in which finish is seen, -1 on timeout.
   task automatic wait_finish(output int lat);
      lat = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (finish === 1'b1) begin
            lat = cyc + 1 - t_acc;
            got_hi = result_hi;
            got_lo = result_lo;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (finish !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b want=0", finish); end
      total++; if (result_hi !== 64'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", result_hi); end
      total++; if (result_lo !== 64'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", result_lo); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_vectors();
      logic [1:0]  ts [8] = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b11};
      logic [63:0] tx [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
      logic [63:0] ty [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h2,
                              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
      logic [63:0] eh [8] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h0, 64'h4000_0000_0000_0000, 64'h1,
                              64'hC000_0000_0000_0000, 64'hC000_0000_0000_0000};
      logic [63:0] el [8] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFEB, 64'h1,
                              64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE,
                              64'h0, 64'h8000_0000_0000_0000};
      int lat;
      logic [127:0] exp;
      for (int i = 0; i < 8; i++) begin
         issue(ts[i], tx[i], ty[i]);
         sb.push_back({eh[i], el[i]});
         wait_finish(lat);
         exp = sb.pop_front();
         $display("vec%0d s=%b x=%h y=%h -> hi=%h lo=%h lat=%0d", i, ts[i], tx[i], ty[i], got_hi, got_lo, lat);
         total++; if (lat !== 35) begin bad++; $display("FAIL vec%0d_latency got=%0d want=35", i, lat); end
         total++; if (got_hi !== exp[127:64]) begin bad++; $display("FAIL vec%0d_hi got=%h want=%h", i, got_hi, exp[127:64]); end
         total++; if (got_lo !== exp[63:0]) begin bad++; $display("FAIL vec%0d_lo got=%h want=%h", i, got_lo, exp[63:0]); end
         @(negedge clk);
         total++; if (finish !== 1'b0) begin bad++; $display("FAIL vec%0d_pulse finish got=%b want=0", i, finish); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL vec%0d_idle busy got=%b want=0", i, busy); end
      end
   endtask

   task automatic test_random();
      int lat;
      logic [1:0]  s;
      logic [63:0] a, b;
      logic [127:0] exp;
      for (int i = 0; i < 10; i++) begin
         s = 2'($urandom_range(0, 3));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (i == 0) a[63] = 1'b1;
         if (i == 1) b[63] = 1'b1;
         issue(s, a, b);
         sb.push_back(model(s, a, b));
         wait_finish(lat);
         exp = sb.pop_front();
         $display("rnd%0d s=%b x=%h y=%h -> hi=%h lo=%h lat=%0d", i, s, a, b, got_hi, got_lo, lat);
         total++; if (lat !== 35) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=35", i, lat); end
         total++; if ({got_hi, got_lo} !== exp) begin bad++; $display("FAIL rnd%0d_product got=%h%h want=%h", i, got_hi, got_lo, exp); end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int lat, ta;
      logic [127:0] exp;
      issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFB, 64'd9);
      sb.push_back(model(2'b11, 64'hFFFF_FFFF_FFFF_FFFB, 64'd9));
      ta = t_acc;
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_init_busy got=%b want=1", busy); end
      repeat (9) @(negedge clk);
      // ignored request at edge T+10
      sign = 2'b00; x = 64'd123; y = 64'd456; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      wait_finish(lat);
      exp = sb.pop_front();
      $display("b2b_a hi=%h lo=%h lat=%0d", got_hi, got_lo, lat);
      total++; if (lat !== 35) begin bad++; $display("FAIL b2b_a_latency got=%0d want=35", lat); end
      total++; if ({got_hi, got_lo} !== exp) begin bad++; $display("FAIL b2b_a_product got=%h%h want=%h", got_hi, got_lo, exp); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_done_busy got=%b want=1", busy); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b want=0", busy); end
      issue(2'b00, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
      sb.push_back(model(2'b00, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321));
      total++; if (t_acc - ta !== 36) begin bad++; $display("FAIL b2b_accept_gap got=%0d want=36", t_acc - ta); end
      wait_finish(lat);
      exp = sb.pop_front();
      $display("b2b_c hi=%h lo=%h lat=%0d", got_hi, got_lo, lat);
      total++; if (lat !== 35) begin bad++; $display("FAIL b2b_c_latency got=%0d want=35", lat); end
      total++; if ({got_hi, got_lo} !== exp) begin bad++; $display("FAIL b2b_c_product got=%h%h want=%h", got_hi, got_lo, exp); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, pulses;
      logic [127:0] exp;
      issue(2'b11, 64'h1111, 64'h2222);
      sb.push_back(model(2'b11, 64'h1111, 64'h2222));
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      void'(sb.pop_front());
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      total++; if (result_hi !== 64'd0) begin bad++; $display("FAIL rstmid_hi got=%h want=0", result_hi); end
      total++; if (result_lo !== 64'd0) begin bad++; $display("FAIL rstmid_lo got=%h want=0", result_lo); end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (finish !== 1'b0) pulses++;
         @(negedge clk);
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_finish_pulses got=%0d want=0", pulses); end
      issue(2'b00, 64'd5, 64'd6);
      sb.push_back({64'd0, 64'd30});
      wait_finish(lat);
      exp = sb.pop_front();
      $display("rstmid_next hi=%h lo=%h lat=%0d", got_hi, got_lo, lat);
      total++; if (lat !== 35) begin bad++; $display("FAIL rstmid_next_latency got=%0d want=35", lat); end
      total++; if ({got_hi, got_lo} !== exp) begin bad++; $display("FAIL rstmid_next_product got=%h%h want=%h", got_hi, got_lo, exp); end
      @(negedge clk);
   endtask

   task automatic test_zero();
      int lat;
      logic [127:0] exp;
      logic [63:0] za [2] = '{64'd0, 64'hABCD};
      logic [63:0] zb [2] = '{64'h1234, 64'd0};
      for (int i = 0; i < 2; i++) begin
         issue(2'b11, za[i], zb[i]);
         sb.push_back(128'd0);
         wait_finish(lat);
         exp = sb.pop_front();
         $display("zero%0d x=%h y=%h -> hi=%h lo=%h lat=%0d", i, za[i], zb[i], got_hi, got_lo, lat);
         total++; if (lat !== ZERO_LAT) begin bad++; $display("FAIL zero%0d_latency got=%0d want=%0d", i, lat, ZERO_LAT); end
         total++; if ({got_hi, got_lo} !== exp) begin bad++; $display("FAIL zero%0d_product got=%h%h want=%h", i, got_hi, got_lo, exp); end
         @(negedge clk);
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero%0d_idle busy got=%b want=0", i, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_zero();
      total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
